// File: rtl/paddle_button_conditioner.sv
// Synchronizes and debounces one player's active-low up/down buttons, applies the both-pressed lockout,
// and emits frame_tick and press pulses. Define BTN_FRAME_LATCH_EN to update up/down only on frame_tick clocks.
module paddle_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    input  logic up_raw,
    input  logic down_raw,
    output logic up,
    output logic down,
    output logic frame_tick,
    output logic up_press,
    output logic down_press
);

    typedef enum logic [1:0] {
        REL    = 2'd0,
        PEND_P = 2'd1,
        PRS    = 2'd2,
        PEND_R = 2'd3
    } db_state_e;

    localparam int               NBTN     = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Index 0 is the up button, index 1 is the down button.
    logic [NBTN-1:0] raw;
    logic [NBTN-1:0] sync1_q;
    logic [NBTN-1:0] sync2_q;
    logic [NBTN-1:0] db;
    logic [NBTN-1:0] press_q;
    logic [NBTN-1:0] press_d;

    db_state_e        state_q [NBTN];
    db_state_e        state_d [NBTN];
    logic [CNT_W-1:0] cnt_q   [NBTN];
    logic [CNT_W-1:0] cnt_d   [NBTN];

    logic vsync_q;
    logic armed_q;
    logic tick_q;
    logic tick_d;
    logic up_q;
    logic up_d;
    logic down_q;
    logic down_d;
    logic lock_up;
    logic lock_down;

    assign raw = {down_raw, up_raw};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= REL;
                cnt_q[i]   <= '0;
            end
            press_q <= '0;
        end else begin
            for (int i = 0; i < NBTN; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            press_q <= press_d;
        end
    end

    // The counter only advances below CNT_LAST, so it can never wrap while pending.
    always_comb begin
        press_d = '0;
        db      = '1;
        for (int i = 0; i < NBTN; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                REL: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = PEND_P;
                        cnt_d[i]   = '0;
                    end
                end
                PEND_P: begin
                    if (sync2_q[i]) begin
                        state_d[i] = REL;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = PRS;
                        press_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                PRS: begin
                    if (sync2_q[i]) begin
                        state_d[i] = PEND_R;
                        cnt_d[i]   = '0;
                    end
                end
                PEND_R: begin
                    if (!sync2_q[i]) begin
                        state_d[i] = PRS;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = REL;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = REL;
                    cnt_d[i]   = '0;
                end
            endcase
            db[i] = !((state_q[i] == PRS) || (state_q[i] == PEND_R));
        end
    end

    // Both held means no motion; each output is forced released.
    always_comb begin
        lock_up   = db[0];
        lock_down = db[1];
        if (!db[0] && !db[1]) begin
            lock_up   = 1'b1;
            lock_down = 1'b1;
        end
    end

    // armed_q suppresses the spurious edge that vsync_q=1 would produce on reset release.
    always_comb begin
        tick_d = armed_q & vsync_q & ~vsync;
`ifdef BTN_FRAME_LATCH_EN
        up_d   = tick_d ? lock_up   : up_q;
        down_d = tick_d ? lock_down : down_q;
`else
        up_d   = lock_up;
        down_d = lock_down;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b1;
            armed_q <= 1'b0;
            tick_q  <= 1'b0;
            up_q    <= 1'b1;
            down_q  <= 1'b1;
        end else begin
            vsync_q <= vsync;
            armed_q <= 1'b1;
            tick_q  <= tick_d;
            up_q    <= up_d;
            down_q  <= down_d;
        end
    end

    assign up         = up_q;
    assign down       = down_q;
    assign frame_tick = tick_q;
    assign up_press   = press_q[0];
    assign down_press = press_q[1];

endmodule

// File: tb/tb_paddle_button_conditioner.sv
// Directed bench for paddle_button_conditioner with DEBOUNCE_CYCLES=4, CNT_W=3.
`ifdef BTN_FRAME_LATCH_EN
`define EXP_LVL(v) (1'b1)
`else
`define EXP_LVL(v) (v)
`endif

module tb_paddle_button_conditioner;

    logic clk;
    logic rst;
    logic vsync;
    logic up_raw;
    logic down_raw;
    logic up;
    logic down;
    logic frame_tick;
    logic up_press;
    logic down_press;

    int n_assert = 0;
    int n_fail   = 0;

    paddle_button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .vsync     (vsync),
        .up_raw    (up_raw),
        .down_raw  (down_raw),
        .up        (up),
        .down      (down),
        .frame_tick(frame_tick),
        .up_press  (up_press),
        .down_press(down_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset with buttons held and vsync low
        rst = 1'b1; up_raw = 1'b0; down_raw = 1'b0; vsync = 1'b0;
        repeat (3) step();
        check("rst_up", up, 1'b1);
        check("rst_down", down, 1'b1);
        check("rst_tick", frame_tick, 1'b0);
        check("rst_up_press", up_press, 1'b0);
        check("rst_down_press", down_press, 1'b0);
        rst = 1'b0; up_raw = 1'b1; down_raw = 1'b1;
        step();
        check("release_tick0", frame_tick, 1'b0);
        step();
        check("release_tick1", frame_tick, 1'b0);
        vsync = 1'b1;
        step();
        step();
        check("idle_up", up, 1'b1);

        // 2: clean press then release
        up_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("press_up_press", up_press, i == 6);
            check("press_up", up, `EXP_LVL(i < 7));
            check("press_down_press", down_press, 1'b0);
        end
        up_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("rel_up_press", up_press, 1'b0);
            check("rel_up", up, `EXP_LVL(i >= 7));
        end

        // 3: bounce, then final stable low
        for (int b = 0; b < 4; b++) begin
            up_raw = (b % 2 == 1);
            repeat (2) begin
                step();
                check("bounce_up_press", up_press, 1'b0);
                check("bounce_up", up, 1'b1);
            end
        end
        up_raw = 1'b0;
        for (int i = 0; i < 9; i++) begin
            step();
            check("bfinal_up_press", up_press, i == 6);
            check("bfinal_up", up, `EXP_LVL(i < 7));
        end
        up_raw = 1'b1;
        repeat (8) step();
        check("bfinal_release_up", up, 1'b1);

        // 4: both buttons held, then down released
        up_raw = 1'b0; down_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("conf_up_press", up_press, i == 6);
            check("conf_down_press", down_press, i == 6);
            check("conf_up", up, 1'b1);
            check("conf_down", down, 1'b1);
        end
        down_raw = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            check("conf_rel_down", down, 1'b1);
            check("conf_rel_down_press", down_press, 1'b0);
            check("conf_rel_up", up, `EXP_LVL(i < 7));
        end
        up_raw = 1'b1;
        repeat (8) step();
        check("conf_end_up", up, 1'b1);
        check("conf_end_down", down, 1'b1);

        // 5: vsync edges
        vsync = 1'b0;
        step();
        check("vs_fall_tick", frame_tick, 1'b1);
        step();
        check("vs_hold_tick0", frame_tick, 1'b0);
        step();
        check("vs_hold_tick1", frame_tick, 1'b0);
        vsync = 1'b1;
        step();
        check("vs_rise_tick", frame_tick, 1'b0);
        step();
        check("vs_high_tick", frame_tick, 1'b0);

        // 6: press mid-frame, then a frame tick
        up_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("fl_up_press", up_press, i == 6);
`ifdef BTN_FRAME_LATCH_EN
            check("fl_up_hold", up, 1'b1);
`else
            check("fl_up_immediate", up, i < 7);
`endif
        end
        vsync = 1'b0;
        step();
        check("fl_tick", frame_tick, 1'b1);
        check("fl_up_at_tick", up, 1'b0);
        step();
        check("fl_tick_end", frame_tick, 1'b0);
        check("fl_up_after_tick", up, 1'b0);
        vsync = 1'b1;
        up_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("fl_rel_up_press", up_press, 1'b0);
`ifdef BTN_FRAME_LATCH_EN
            check("fl_rel_up_hold", up, 1'b0);
`else
            check("fl_rel_up", up, i >= 7);
`endif
        end
        vsync = 1'b0;
        step();
        check("fl_rel_tick", frame_tick, 1'b1);
        check("fl_rel_up_final", up, 1'b1);
        vsync = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
